// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the operand-fetch stage.
//
// Holds the default data and register-number widths and the encoding of the
// per-operand forwarding choice made by fwd_sel.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // Where an operand was taken from, in priority order.
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_t;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel -- bypass selection for one source operand.
//
// Ports:
//   src          source register number being read
//   ex_en        the held (execute-stage) instruction is a valid non-load write
//   ex_rd/ex_alu destination and result of the held instruction
//   mem_*        memory-stage write enable, load flag, destination, ALU result, load data
//   wb_*         write-back port as seen by the register file
//   rf_d         combinational register-file read data for src
//   sel          chosen source (fwd_t)
//   value        chosen operand value
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic [AW-1:0] src,
    input  logic          ex_en,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_alu,
    input  logic          mem_wreg,
    input  logic          mem_mem2reg,
    input  logic [AW-1:0] mem_rn,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] mem_mo,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wn,
    input  logic [DW-1:0] wb_d,
    input  logic [DW-1:0] rf_d,
    output fwd_t          sel,
    output logic [DW-1:0] value
);

    // Priority chain: the youngest producer wins. Register 0 is tested first,
    // so a stage writing register 0 can never reach a forwarding match below.
    always_comb begin
        sel = FWD_RF;
        if (src == '0) begin
            sel = FWD_ZERO;
        end else if (ex_en && (ex_rd == src)) begin
            sel = FWD_EX;
        end else if (mem_wreg && (mem_rn == src)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_wn == src)) begin
            sel = FWD_WB;
        end
    end

    // Value mux driven by the select code; a MEM hit returns load data for loads.
    always_comb begin
        value = rf_d;
        case (sel)
            FWD_ZERO: value = '0;
            FWD_EX:   value = ex_alu;
            FWD_MEM:  value = mem_mem2reg ? mem_mo : mem_alu;
            FWD_WB:   value = wb_d;
            default:  value = rf_d;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch -- decode-to-execute operand fetch with bypassing and
// load-use stall detection.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          decoded-instruction handshake
//   in_rs/in_rt, in_use_*      source numbers and source-used flags
//   in_rd/in_wreg/in_mem2reg   destination, write enable, load flag
//   rna/rnb, qa/qb             register-file read numbers and read data
//   ex_alu                     result of the instruction held in the output register
//   mem_*                      memory-stage bypass inputs
//   wb_*                       write-back port
//   flush                      discard held and incoming instruction
//   out_valid/out_ready        execute-stage handshake
//   out_a/out_b/out_rd/out_wreg/out_mem2reg   registered instruction to execute
//   stall_cnt                  saturating count of load-use stall cycles
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic          in_use_rs,
    input  logic          in_use_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          in_wreg,
    input  logic          in_mem2reg,
    output logic [AW-1:0] rna,
    output logic [AW-1:0] rnb,
    input  logic [DW-1:0] qa,
    input  logic [DW-1:0] qb,
    input  logic [DW-1:0] ex_alu,
    input  logic          mem_wreg,
    input  logic          mem_mem2reg,
    input  logic [AW-1:0] mem_rn,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] mem_mo,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wn,
    input  logic [DW-1:0] wb_d,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [AW-1:0] out_rd,
    output logic          out_wreg,
    output logic          out_mem2reg,
    output logic [15:0]   stall_cnt
);

    logic          ex_en;
    logic          hazard;
    logic          transfer;
    logic          same_src;
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;
    logic [DW-1:0] op_b;
    fwd_t          sel_a_unused;
    fwd_t          sel_b_unused;

    assign rna = in_rs;
    assign rnb = in_rt;

    // A held load cannot forward from EX: its data only exists in MEM next cycle.
    assign ex_en = out_valid && out_wreg && !out_mem2reg;

    // Load-use: the held instruction is a load whose result a used source needs.
    assign hazard = in_valid && out_valid && out_wreg && out_mem2reg && (out_rd != '0) &&
                    ((in_use_rs && (in_rs == out_rd)) || (in_use_rt && (in_rt == out_rd)));

    assign in_ready = rst_n && !hazard && (!out_valid || out_ready) && !flush;
    assign transfer = in_valid && in_ready;

    // Identical used sources share operand A's selection so both see one value.
    assign same_src = in_use_rs && in_use_rt && (in_rs == in_rt);
    assign op_b     = same_src ? a_val : b_val;

    fwd_sel #(.DW(DW), .AW(AW)) u_fwd_a (
        .src         (in_rs),
        .ex_en       (ex_en),
        .ex_rd       (out_rd),
        .ex_alu      (ex_alu),
        .mem_wreg    (mem_wreg),
        .mem_mem2reg (mem_mem2reg),
        .mem_rn      (mem_rn),
        .mem_alu     (mem_alu),
        .mem_mo      (mem_mo),
        .wb_we       (wb_we),
        .wb_wn       (wb_wn),
        .wb_d        (wb_d),
        .rf_d        (qa),
        .sel         (sel_a_unused),
        .value       (a_val)
    );

    fwd_sel #(.DW(DW), .AW(AW)) u_fwd_b (
        .src         (in_rt),
        .ex_en       (ex_en),
        .ex_rd       (out_rd),
        .ex_alu      (ex_alu),
        .mem_wreg    (mem_wreg),
        .mem_mem2reg (mem_mem2reg),
        .mem_rn      (mem_rn),
        .mem_alu     (mem_alu),
        .mem_mo      (mem_mo),
        .wb_we       (wb_we),
        .wb_wn       (wb_wn),
        .wb_d        (wb_d),
        .rf_d        (qb),
        .sel         (sel_b_unused),
        .value       (b_val)
    );

    // Output register: reset beats flush, flush beats transfer, transfer beats
    // bubble, otherwise hold. Operand fields only change on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_rd      <= '0;
            out_wreg    <= 1'b0;
            out_mem2reg <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (hazard && !flush && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (transfer) begin
                out_valid   <= 1'b1;
                out_a       <= a_val;
                out_b       <= op_b;
                out_rd      <= in_rd;
                out_wreg    <= in_wreg;
                out_mem2reg <= in_mem2reg;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch -- self-checking bench for operand_fetch.
//
// Directed scenarios for bypass priority, load-use stall, write-back bypass,
// backpressure with flush, then randomized traffic against a behavioural model
// of the fetch stage kept in this file.
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          rst_n;
        logic          in_valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          use_rs;
        logic          use_rt;
        logic [AW-1:0] rd;
        logic          wreg;
        logic          mem2reg;
        logic [DW-1:0] qa;
        logic [DW-1:0] qb;
        logic [DW-1:0] ex_alu;
        logic          mem_wreg;
        logic          mem_mem2reg;
        logic [AW-1:0] mem_rn;
        logic [DW-1:0] mem_alu;
        logic [DW-1:0] mem_mo;
        logic          wb_we;
        logic [AW-1:0] wb_wn;
        logic [DW-1:0] wb_d;
        logic          flush;
        logic          out_ready;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs, in_rt, in_rd;
    logic          in_use_rs, in_use_rt, in_wreg, in_mem2reg;
    logic [AW-1:0] rna, rnb;
    logic [DW-1:0] qa, qb, ex_alu;
    logic          mem_wreg, mem_mem2reg;
    logic [AW-1:0] mem_rn;
    logic [DW-1:0] mem_alu, mem_mo;
    logic          wb_we;
    logic [AW-1:0] wb_wn;
    logic [DW-1:0] wb_d;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_a, out_b;
    logic [AW-1:0] out_rd;
    logic          out_wreg, out_mem2reg;
    logic [15:0]   stall_cnt;

    int checks = 0;
    int errors = 0;
    logic last_ready;

    // Model of what the execute stage currently holds.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    logic [AW-1:0] m_rd = '0;
    logic          m_wreg = 1'b0;
    logic          m_load = 1'b0;
    int            m_stalls = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_rd(in_rd), .in_wreg(in_wreg), .in_mem2reg(in_mem2reg),
        .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_mem2reg(mem_mem2reg), .mem_rn(mem_rn),
        .mem_alu(mem_alu), .mem_mo(mem_mo),
        .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_wreg(out_wreg), .out_mem2reg(out_mem2reg),
        .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        s.rst_n     = 1'b1;
        s.out_ready = 1'b1;
        return s;
    endfunction

    function automatic logic [AW-1:0] randReg();
        if ($urandom_range(0, 7) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 3));
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst_n       = ($urandom_range(0, 49) != 0);
        s.in_valid    = ($urandom_range(0, 3) != 0);
        s.rs          = randReg();
        s.rt          = randReg();
        s.use_rs      = ($urandom_range(0, 3) != 0);
        s.use_rt      = ($urandom_range(0, 3) != 0);
        s.rd          = randReg();
        s.wreg        = ($urandom_range(0, 3) != 0);
        s.mem2reg     = ($urandom_range(0, 2) == 0);
        s.qa          = $urandom;
        s.qb          = $urandom;
        s.ex_alu      = $urandom;
        s.mem_wreg    = $urandom_range(0, 1) != 0;
        s.mem_mem2reg = $urandom_range(0, 1) != 0;
        s.mem_rn      = randReg();
        s.mem_alu     = $urandom;
        s.mem_mo      = $urandom;
        s.wb_we       = $urandom_range(0, 1) != 0;
        s.wb_wn       = randReg();
        s.wb_d        = $urandom;
        s.flush       = ($urandom_range(0, 9) == 0);
        s.out_ready   = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    // Newest producer of a register wins; register 0 is always zero.
    function automatic logic [DW-1:0] expectOperand(input logic [AW-1:0] src, input logic [DW-1:0] rf, input stim_t s);
        if (src == 0) return '0;
        if (m_valid && m_wreg && !m_load && m_rd == src) return s.ex_alu;
        if (s.mem_wreg && s.mem_rn == src) return s.mem_mem2reg ? s.mem_mo : s.mem_alu;
        if (s.wb_we && s.wb_wn == src) return s.wb_d;
        return rf;
    endfunction

    task automatic applyStimulus(input stim_t s);
        logic          stall;
        logic          ready;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        rst_n = s.rst_n;       in_valid = s.in_valid;
        in_rs = s.rs;          in_rt = s.rt;
        in_use_rs = s.use_rs;  in_use_rt = s.use_rt;
        in_rd = s.rd;          in_wreg = s.wreg;       in_mem2reg = s.mem2reg;
        qa = s.qa;             qb = s.qb;              ex_alu = s.ex_alu;
        mem_wreg = s.mem_wreg; mem_mem2reg = s.mem_mem2reg; mem_rn = s.mem_rn;
        mem_alu = s.mem_alu;   mem_mo = s.mem_mo;
        wb_we = s.wb_we;       wb_wn = s.wb_wn;        wb_d = s.wb_d;
        flush = s.flush;       out_ready = s.out_ready;
        #1;
        stall = s.in_valid && m_valid && m_wreg && m_load && (m_rd != 0) &&
                ((s.use_rs && s.rs == m_rd) || (s.use_rt && s.rt == m_rd));
        ready = s.rst_n && !stall && (!m_valid || s.out_ready) && !s.flush;
        checkOutput("in_ready", 32'(in_ready), 32'(ready));
        checkOutput("rna", 32'(rna), 32'(s.rs));
        checkOutput("rnb", 32'(rnb), 32'(s.rt));
        last_ready = in_ready;

        ea = expectOperand(s.rs, s.qa, s);
        eb = (s.use_rs && s.use_rt && s.rs == s.rt) ? ea : expectOperand(s.rt, s.qb, s);
        if (!s.rst_n) begin
            m_valid = 0; m_a = '0; m_b = '0; m_rd = '0; m_wreg = 0; m_load = 0; m_stalls = 0;
        end else begin
            if (stall && !s.flush && m_stalls < 65535) m_stalls++;
            if (s.flush) m_valid = 0;
            else if (s.in_valid && ready) begin
                m_valid = 1; m_a = ea; m_b = eb; m_rd = s.rd; m_wreg = s.wreg; m_load = s.mem2reg;
            end else if (m_valid && s.out_ready) m_valid = 0;
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("out_a", out_a, m_a);
        checkOutput("out_b", out_b, m_b);
        checkOutput("out_rd", 32'(out_rd), 32'(m_rd));
        checkOutput("out_wreg", 32'(out_wreg), 32'(m_wreg));
        checkOutput("out_mem2reg", 32'(out_mem2reg), 32'(m_load));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    endtask

    initial begin
        stim_t s;

        // Reset held for two cycles, then an idle cycle must be ready.
        s = idleStim();
        s.rst_n = 1'b0;
        s.in_valid = 1'b1;
        s.rd = 5'd4;
        s.wreg = 1'b1;
        applyStimulus(s);
        checkOutput("reset_ready_low", 32'(last_ready), 32'd0);
        applyStimulus(s);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        s = idleStim();
        applyStimulus(s);
        checkOutput("ready_after_reset", 32'(last_ready), 32'd1);

        // EX bypass: ALU instruction to r3, then a reader of r3.
        s = idleStim(); s.in_valid = 1; s.rd = 5'd3; s.wreg = 1;
        applyStimulus(s);
        s = idleStim(); s.in_valid = 1; s.rs = 5'd3; s.use_rs = 1; s.ex_alu = 32'h11; s.qa = 32'h99;
        applyStimulus(s);
        checkOutput("ex_bypass", out_a, 32'h11);

        // Load to r5, dependent reader stalls one cycle then bypasses from MEM.
        s = idleStim(); s.in_valid = 1; s.rd = 5'd5; s.wreg = 1; s.mem2reg = 1;
        applyStimulus(s);
        s = idleStim(); s.in_valid = 1; s.rt = 5'd5; s.use_rt = 1; s.qb = 32'h77;
        applyStimulus(s);
        checkOutput("load_use_ready", 32'(last_ready), 32'd0);
        checkOutput("load_use_stalls", 32'(stall_cnt), 32'd1);
        s.mem_wreg = 1; s.mem_mem2reg = 1; s.mem_rn = 5'd5; s.mem_mo = 32'hCAFE; s.mem_alu = 32'h1234;
        applyStimulus(s);
        checkOutput("load_use_release", 32'(last_ready), 32'd1);
        checkOutput("mem_load_bypass", out_b, 32'hCAFE);

        // Write-back bypass over stale register data, and register 0.
        s = idleStim(); s.in_valid = 1; s.rs = 5'd7; s.use_rs = 1; s.qa = 32'h0;
        s.wb_we = 1; s.wb_wn = 5'd7; s.wb_d = 32'h55;
        applyStimulus(s);
        checkOutput("wb_bypass", out_a, 32'h55);
        s.rs = 5'd0; s.wb_wn = 5'd0; s.qa = 32'hDEAD;
        applyStimulus(s);
        checkOutput("reg_zero", out_a, 32'h0);

        // Backpressure for three cycles with a flush in the second.
        s = idleStim(); s.in_valid = 1; s.rd = 5'd2; s.wreg = 1; s.rs = 5'd1; s.qa = 32'hABCD;
        applyStimulus(s);
        s = idleStim(); s.in_valid = 1; s.out_ready = 0; s.rs = 5'd2; s.qa = 32'h1;
        applyStimulus(s);
        checkOutput("stall_ready", 32'(last_ready), 32'd0);
        checkOutput("stall_hold_a", out_a, 32'hABCD);
        s.flush = 1;
        applyStimulus(s);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        s.flush = 0; s.in_valid = 0;
        applyStimulus(s);

        // EX and MEM both write r9: EX is younger and wins.
        s = idleStim(); s.in_valid = 1; s.rd = 5'd9; s.wreg = 1;
        applyStimulus(s);
        s = idleStim(); s.in_valid = 1; s.rs = 5'd9; s.use_rs = 1;
        s.ex_alu = 32'h1; s.mem_wreg = 1; s.mem_rn = 5'd9; s.mem_alu = 32'h2;
        applyStimulus(s);
        checkOutput("ex_over_mem", out_a, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(randStim());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DW, default 32, data width of register values and results.
REQ-002 Parameter AW, default 5, register-number width; register 0 reads as zero.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  decoded-instruction handshake; transfer when both are high at a clock edge.
REQ-006 in_rs, in_rt  in  AW  source register numbers; in_use_rs, in_use_rt  in  1  source-used flags.
REQ-007 in_rd  in  AW, in_wreg  in  1, in_mem2reg  in  1  destination, write-enable and load flag of the incoming instruction.
REQ-008 rna, rnb  out  AW  register-file read numbers; qa, qb  in  DW  combinational register-file read data.
REQ-009 ex_alu  in  DW  result of the instruction currently held in this block's output register.
REQ-010 mem_wreg, mem_mem2reg  in  1; mem_rn  in  AW; mem_alu, mem_mo  in  DW  memory-stage destination, ALU result and load data.
REQ-011 wb_we  in  1, wb_wn  in  AW, wb_d  in  DW  write-back port, as driven into the register file.
REQ-012 flush  in  1  discard the held and incoming instruction.
REQ-013 out_valid/out_ready  out/in  1/1  execute-stage handshake; out_a, out_b  out  DW; out_rd  out  AW; out_wreg, out_mem2reg  out  1.
REQ-014 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-015 rna SHALL equal in_rs and rnb SHALL equal in_rt combinationally, with no latency.
REQ-016 Operand selection per source SHALL use the following priority: (1) register 0 -> 0; (2) EX match (out_valid, out_wreg, out_rd==src, !out_mem2reg) -> ex_alu; (3) MEM match (mem_wreg, mem_rn==src) -> mem_mo if mem_mem2reg, else mem_alu; (4) WB match (wb_we, wb_wn==src) -> wb_d; (5) otherwise qa/qb.
REQ-017 A destination of 0 SHALL never produce a forwarding match.
REQ-018 Load-use hazard SHALL be asserted when in_valid, out_valid, out_wreg, out_mem2reg and out_rd!=0 hold, and out_rd matches a used source (in_use_rs/in_rs or in_use_rt/in_rt).
REQ-019 in_ready SHALL equal !hazard && (!out_valid || out_ready) && !flush.
REQ-020 On transfer, the output registers SHALL load the selected operands, in_rd, in_wreg and in_mem2reg, and out_valid SHALL be set to 1 at the next edge.
REQ-021 When out_valid && out_ready and no transfer occurs, out_valid SHALL clear at the next edge (bubble); all other output registers SHALL hold their values.
REQ-022 When out_valid && !out_ready, all output registers SHALL hold their values.
REQ-023 A hazard SHALL last exactly one cycle per load: once the load leaves the output register, the dependent instruction SHALL take its operand from MEM (mem_mo).
REQ-024 flush SHALL clear out_valid at the next edge, accept no transfer, and take priority over both transfer and hold.
REQ-025 stall_cnt SHALL increment on every cycle with hazard && !flush and SHALL saturate at 0xFFFF.
REQ-026 An instruction that uses both sources with in_rs==in_rt SHALL receive identical operands from a single selection.

Reset
REQ-027 When rst_n is low at a clock edge: out_valid=0, out_a=0, out_b=0, out_rd=0, out_wreg=0, out_mem2reg=0, stall_cnt=0.
REQ-028 in_ready SHALL be driven 0 while rst_n is low, and reset SHALL take priority over flush and over any transfer in progress.

Structure
REQ-029 A shared package cpu_pkg SHALL hold DW, AW and the forward-select encoding FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF.
REQ-030 A sub-module fwd_sel SHALL be instantiated once per operand; it takes a source number and the stage bypass inputs, and returns the select code and the selected value.

Verification
REQ-031 rst_n low for 2 cycles, then high -> all outputs 0, stall_cnt=0, then in_ready=1.
REQ-032 Held instruction with out_rd=3, out_wreg=1, ex_alu=0x11; incoming in_rs=3 -> out_a=0x11 after the transfer.
REQ-033 Held load with out_rd=5; incoming in_rt=5, in_use_rt=1 -> in_ready=0 for 1 cycle and stall_cnt=1; next cycle with mem_mem2reg=1, mem_rn=5, mem_mo=0xCAFE -> out_b=0xCAFE.
REQ-034 wb_we=1, wb_wn=7, wb_d=0x55, qa=0x00 (stale), in_rs=7 -> out_a=0x55; the same case with in_rs=0 -> out_a=0.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; flush in cycle 2 -> out_valid=0 in the next cycle.
REQ-036 EX and MEM both target register 9 (ex_alu=1, mem_alu=2), in_rs=9 -> out_a=1.
